// File: rtl/alu_pkg.sv
// Shared opcode encoding, flag bit positions and the per-opcode flag-write mask for alu_pipe.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_XOR    = 4'd2,
        OP_RED    = 4'd3,
        OP_SLL    = 4'd4,
        OP_SRA    = 4'd5,
        OP_ROR    = 4'd6,
        OP_PADDSB = 4'd7,
        OP_LW     = 4'd8,
        OP_SW     = 4'd9
    } opcode_t;

    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    function automatic logic [2:0] flag_wmask(input logic [3:0] op);
        logic [2:0] m;
        m = 3'b000;
        case (op)
            OP_ADD, OP_SUB: begin
                m[FLAG_Z] = 1'b1;
                m[FLAG_N] = 1'b1;
                m[FLAG_V] = 1'b1;
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[FLAG_Z] = 1'b1;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational left shift, arithmetic right shift and right rotate of a by shamt.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a;
        case (op)
            OP_SLL:  y = a << shamt;
            OP_SRA:  y = $unsigned($signed(a) >>> shamt);
            // Rotating the doubled word keeps shamt=0 a clean pass-through.
            OP_ROR:  y = WIDTH'({a, a} >> shamt);
            default: y = a;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU; result valid two cycles after accept, holds at most two ops under backpressure.
// Optional byte-reduction opcode enabled by macro ALU_PIPE_RED_EN (otherwise opcode 3 is illegal).
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags,
    output logic             illegal_op
);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [SHW-1:0]   s1_shamt;

    logic             s2_valid;
    logic [2:0]       s2_fval;
    logic [2:0]       s2_fmask;

    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic             retire;

    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH-1:0] shf_y;
    logic [WIDTH-1:0] padd_res;
    logic [4:0]       lane;
    logic [WIDTH-1:0] nxt_res;
    logic             nxt_ill;
    logic             nxt_v;
    logic [2:0]       nxt_flags;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = s1_valid && s2_adv;
    assign in_ready  = !s1_valid || s2_adv;
    assign accept    = in_valid && in_ready;
    assign retire    = s2_valid && out_ready;
    assign out_valid = s2_valid;

    assign add_ext = {s1_a[WIDTH-1], s1_a} + {s1_b[WIDTH-1], s1_b};
    assign sub_ext = {s1_a[WIDTH-1], s1_a} - {s1_b[WIDTH-1], s1_b};

    alu_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
        .op    (s1_op),
        .a     (s1_a),
        .shamt (s1_shamt),
        .y     (shf_y)
    );

    always_comb begin
        padd_res = '0;
        lane     = '0;
        for (int i = 0; i < WIDTH/4; i++) begin
            lane = {s1_a[4*i+3], s1_a[4*i +: 4]} + {s1_b[4*i+3], s1_b[4*i +: 4]};
            if (lane[4] != lane[3])
                padd_res[4*i +: 4] = lane[4] ? 4'h8 : 4'h7;
            else
                padd_res[4*i +: 4] = lane[3:0];
        end
    end

`ifdef ALU_PIPE_RED_EN
    logic [WIDTH-1:0] red_sum;

    always_comb begin
        red_sum = '0;
        for (int i = 0; i < WIDTH/8; i++) begin
            red_sum = red_sum + WIDTH'($signed(s1_a[8*i +: 8]))
                              + WIDTH'($signed(s1_b[8*i +: 8]));
        end
    end
`endif

    // A sign mismatch between the guard bit and the MSB marks signed overflow.
    always_comb begin
        nxt_res = '0;
        nxt_ill = 1'b0;
        nxt_v   = 1'b0;
        case (s1_op)
            OP_ADD: begin
                nxt_v   = add_ext[WIDTH] ^ add_ext[WIDTH-1];
                nxt_res = nxt_v ? (add_ext[WIDTH] ? MIN_NEG : MAX_POS) : add_ext[WIDTH-1:0];
            end
            OP_SUB: begin
                nxt_v   = sub_ext[WIDTH] ^ sub_ext[WIDTH-1];
                nxt_res = nxt_v ? (sub_ext[WIDTH] ? MIN_NEG : MAX_POS) : sub_ext[WIDTH-1:0];
            end
            OP_XOR: nxt_res = s1_a ^ s1_b;
`ifdef ALU_PIPE_RED_EN
            OP_RED: nxt_res = red_sum;
`endif
            OP_SLL, OP_SRA, OP_ROR: nxt_res = shf_y;
            OP_PADDSB: nxt_res = padd_res;
            OP_LW, OP_SW: nxt_res = {s1_a[WIDTH-1:1], 1'b0} + s1_b;
            default: nxt_ill = 1'b1;
        endcase
        nxt_flags = {nxt_res == '0, nxt_res[WIDTH-1], nxt_v};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_op      <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_shamt   <= '0;
            s2_valid   <= 1'b0;
            s2_fval    <= '0;
            s2_fmask   <= '0;
            result     <= '0;
            illegal_op <= 1'b0;
            flags      <= '0;
        end else begin
            if (in_ready)
                s1_valid <= in_valid;
            if (accept) begin
                s1_op    <= opcode;
                s1_a     <= a;
                s1_b     <= b;
                s1_shamt <= shamt;
            end
            if (s2_adv)
                s2_valid <= s1_valid;
            if (s1_adv) begin
                result     <= nxt_res;
                illegal_op <= nxt_ill;
                s2_fval    <= nxt_flags;
                s2_fmask   <= nxt_ill ? 3'b000 : flag_wmask(s1_op);
            end
            // Flags only change when the consumer actually takes the result.
            if (retire)
                flags <= (flags & ~s2_fmask) | (s2_fval & s2_fmask);
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH=16: latency, arithmetic, flags, backpressure and reset flush.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [2:0]  flags;
    logic        illegal_op;

    int n_vec = 0;
    int n_err = 0;

    alu_pipe #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .a          (a),
        .b          (b),
        .shamt      (shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flags      (flags),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Single op with out_ready high: accept, S1, S2 (out_valid), then retire and flag commit.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a_v,
                          input logic [15:0] b_v, input logic [3:0] sh, input logic [15:0] exp_r,
                          input logic exp_ill, input logic [2:0] exp_f);
        opcode   = op;
        a        = a_v;
        b        = b_v;
        shamt    = sh;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check({tag, "_lat1"}, {31'b0, out_valid}, 32'd0);
        tick();
        check({tag, "_lat2"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_result"}, {16'b0, result}, {16'b0, exp_r});
        check({tag, "_illegal"}, {31'b0, illegal_op}, {31'b0, exp_ill});
        tick();
        check({tag, "_flags"}, {29'b0, flags}, {29'b0, exp_f});
        check({tag, "_drained"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        opcode    = '0;
        a         = '0;
        b         = '0;
        shamt     = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_flags", {29'b0, flags}, 32'd0);
        check("rst_result", {16'b0, result}, 32'd0);
        check("rst_illegal", {31'b0, illegal_op}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Flags are {Z,N,V}.
        run_op("add_sat_pos", 4'd0, 16'h7FFF, 16'h0001, 4'd0, 16'h7FFF, 1'b0, 3'b001);
        run_op("sub_zero",    4'd1, 16'h0005, 16'h0005, 4'd0, 16'h0000, 1'b0, 3'b100);
        run_op("xor_ff",      4'd2, 16'h00F0, 16'h000F, 4'd0, 16'h00FF, 1'b0, 3'b000);
        run_op("sub_sat_neg", 4'd1, 16'h8000, 16'h0001, 4'd0, 16'h8000, 1'b0, 3'b011);
        run_op("xor_zero",    4'd2, 16'hAAAA, 16'hAAAA, 4'd0, 16'h0000, 1'b0, 3'b111);
        run_op("paddsb_sat",  4'd7, 16'h7777, 16'h1111, 4'd0, 16'h7777, 1'b0, 3'b111);
        run_op("sra_4",       4'd5, 16'h8000, 16'h0000, 4'd4, 16'hF800, 1'b0, 3'b011);
        run_op("ror_1",       4'd6, 16'h0001, 16'h0000, 4'd1, 16'h8000, 1'b0, 3'b011);
        run_op("sll_out",     4'd4, 16'h0100, 16'h0000, 4'd8, 16'h0000, 1'b0, 3'b111);
        run_op("ror_0",       4'd6, 16'h1234, 16'h0000, 4'd0, 16'h1234, 1'b0, 3'b011);
        run_op("lw",          4'd8, 16'h1235, 16'h0010, 4'd0, 16'h1244, 1'b0, 3'b011);
        run_op("sw_wrap",     4'd9, 16'hFFFF, 16'h0002, 4'd0, 16'h0000, 1'b0, 3'b011);
        run_op("paddsb_neg",  4'd7, 16'h8000, 16'h8000, 4'd0, 16'h8000, 1'b0, 3'b011);
        run_op("add_zero",    4'd0, 16'h0003, 16'hFFFD, 4'd0, 16'h0000, 1'b0, 3'b100);
        run_op("illegal_c",   4'hC, 16'h1234, 16'h5678, 4'd3, 16'h0000, 1'b1, 3'b100);
`ifdef ALU_PIPE_RED_EN
        run_op("red",         4'd3, 16'h01FF, 16'h0280, 4'd0, 16'hFF82, 1'b0, 3'b100);
`else
        run_op("red_illegal", 4'd3, 16'h01FF, 16'h0280, 4'd0, 16'h0000, 1'b1, 3'b100);
`endif

        // Backpressure: three back-to-back XORs, consumer stalled for four edges.
        out_ready = 1'b0;
        opcode    = 4'd2;
        b         = 16'h0000;
        a         = 16'h0001;
        in_valid  = 1'b1;
        tick();
        check("bp_rdy_after1", {31'b0, in_ready}, 32'd1);
        a = 16'h0002;
        tick();
        check("bp_rdy_full", {31'b0, in_ready}, 32'd0);
        a = 16'h0003;
        tick();
        check("bp_hold_rdy", {31'b0, in_ready}, 32'd0);
        check("bp_hold_vld", {31'b0, out_valid}, 32'd1);
        check("bp_hold_res", {16'b0, result}, 32'h0001);
        tick();
        check("bp_hold2_vld", {31'b0, out_valid}, 32'd1);
        check("bp_hold2_res", {16'b0, result}, 32'h0001);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp_ret2_vld", {31'b0, out_valid}, 32'd1);
        check("bp_ret2_res", {16'b0, result}, 32'h0002);
        tick();
        check("bp_ret3_vld", {31'b0, out_valid}, 32'd1);
        check("bp_ret3_res", {16'b0, result}, 32'h0003);
        tick();
        check("bp_empty", {31'b0, out_valid}, 32'd0);
        check("bp_flags", {29'b0, flags}, 32'd0);

        // Reset flush with two ops in flight after flags were made non-zero.
        run_op("pre_rst_add", 4'd0, 16'h8000, 16'hFFFF, 4'd0, 16'h8000, 1'b0, 3'b011);
        out_ready = 1'b0;
        opcode    = 4'd0;
        a         = 16'h7FFF;
        b         = 16'h0001;
        in_valid  = 1'b1;
        tick();
        opcode = 4'd1;
        a      = 16'h0005;
        b      = 16'h0005;
        tick();
        check("flush_full", {31'b0, out_valid}, 32'd1);
        rst       = 1'b1;
        out_ready = 1'b1;
        opcode    = 4'd2;
        a         = 16'h00F0;
        b         = 16'h000F;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_flags", {29'b0, flags}, 32'd0);
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_no_retire", {31'b0, out_valid}, 32'd0);
        end
        check("flush_flags_kept", {29'b0, flags}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter SHW, default $clog2(WIDTH), width of the shift-amount port.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port in_valid  input  1  operation presented.
REQ-006 Port in_ready  output  1  block can accept; transfer when in_valid && in_ready.
REQ-007 Port opcode  input  4  operation select (encoding in REQ-013).
REQ-008 Port a, b  input  WIDTH each  operands.
REQ-009 Port shamt  input  SHW  shift/rotate amount.
REQ-010 Port out_valid  output  1  result available.
REQ-011 Port out_ready  input  1  consumer accepts; retire when out_valid && out_ready.
REQ-012 Ports result (output, WIDTH), flags (output, 3, {Z,N,V} committed flag register), illegal_op (output, 1, qualifies result).

Function
REQ-013 Opcodes: 0 ADD, 1 SUB, 2 XOR, 3 RED, 4 SLL, 5 SRA, 6 ROR, 7 PADDSB, 8 LW, 9 SW, 10-15 illegal.
REQ-014 Two-stage pipeline: S1 registers opcode/operands; S2 registers computed result; the first out_valid SHALL occur exactly 2 cycles after acceptance with out_ready held high.
REQ-015 A stage SHALL advance only when the next stage is empty or retiring in the same cycle; in_ready = !S1_valid || S1 advancing; full throughput is 1 op/cycle.
REQ-016 While out_valid && !out_ready, result, illegal_op, and out_valid SHALL hold stable; a maximum of 2 operations are held, and ordering SHALL be preserved.
REQ-017 ADD/SUB: signed two's complement; on overflow, saturate to the most-positive/most-negative value and set V=1, else V=0.
REQ-018 XOR: a ^ b.
REQ-019 RED: sign-extended sum of all WIDTH/8 signed bytes of a and b, truncated to WIDTH.
REQ-020 SLL/SRA/ROR: a shifted or rotated by shamt; SRA fills with sign; shamt=0 passes a.
REQ-021 PADDSB: independent signed 4-bit lanes, each lane saturating to 0x7/0x8.
REQ-022 LW/SW: result = (a & ~1) + b, modulo 2^WIDTH.
REQ-023 Illegal opcode: result 0, illegal_op=1, no flag update.
REQ-024 Flags SHALL commit only on the retire handshake: ADD/SUB write Z,N,V; XOR/SLL/SRA/ROR write Z only; other operations leave flags unchanged.
REQ-025 Z SHALL be computed on the final (saturated) result; N = result[WIDTH-1].

Reset
REQ-026 On rst=1 at a clock edge: S1/S2 valid cleared, out_valid=0, flags=3'b000, result=0, illegal_op=0, with in_ready=1 the following cycle.
REQ-027 Reset mid-operation SHALL discard all in-flight ops without retiring or committing flags; in_valid is ignored during the reset cycle.

Configuration
REQ-028 Macro ALU_PIPE_RED_EN: when defined, RED is implemented per REQ-019; when undefined, opcode 3 is treated as illegal per REQ-023 and no RED adder tree is synthesised.

Structure
REQ-029 Shared package alu_pkg SHALL hold the opcode enum, flag-index constants, and a function classifying flag-write masks per opcode.
REQ-030 One sub-module, alu_shifter (parametrised on WIDTH/SHW), SHALL implement SLL/SRA/ROR; all other operations are inline in S2 logic.

Verification (WIDTH=16)
REQ-031 ADD a=0x7FFF b=0x0001 -> result 0x7FFF, flags Z=0 N=0 V=1, out_valid 2 cycles after accept.
REQ-032 SUB 0x0005-0x0005 -> 0x0000 with Z=1; then XOR 0x00F0^0x000F -> 0x00FF, Z=0, with N and V unchanged from the SUB.
REQ-033 PADDSB 0x7777+0x1111 -> 0x7777; SRA 0x8000 by 4 -> 0xF800; ROR 0x0001 by 1 -> 0x8000; flags unchanged by PADDSB.
REQ-034 Three back-to-back ops with out_ready=0 for 4 cycles -> in_ready falls after 2 accepted; releasing out_ready retires all in order, one per cycle.
REQ-035 Opcode 0xC -> result 0x0000, illegal_op=1, flags unchanged; with ALU_PIPE_RED_EN undefined, opcode 3 gives the same response.
REQ-036 rst asserted with 2 ops in flight -> out_valid=0 and flags=000 next cycle, and neither op ever retires.
